// File: rtl/gate_pkg.sv
// Shared types and limits for the gate truth-table engine.
package gate_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_BUF  = 3'd6,
    OP_NOT  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int N_IN_MIN = 1;
  localparam int N_IN_MAX = 6;

endpackage

// File: rtl/gate_truth_table_engine_if.sv
// Request/status bundle for the truth-table engine. master = requester, slave = engine.
interface gate_truth_table_engine_if
  import gate_pkg::*;
#(
  parameter int N_IN = 2
);
  localparam int TT_W = 2 ** N_IN;

  logic            start;
  op_e             op;
  logic            busy;
  logic            done;
  logic [N_IN-1:0] vec_out;
  logic            bit_out;
  logic            bit_valid;
  logic [TT_W-1:0] tt;

  modport master (
    output start, op,
    input  busy, done, vec_out, bit_out, bit_valid, tt
  );

  modport slave (
    input  start, op,
    output busy, done, vec_out, bit_out, bit_valid, tt
  );

endinterface

// File: rtl/nin_gate.sv
// Combinational N-input gate with run-time selectable function.
module nin_gate
  import gate_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [N_IN-1:0] vec,
  input  op_e             op,
  output logic            y
);

  // Reductions make N_IN=1 fall out naturally: AND/OR/XOR collapse to vec[0].
  always_comb begin
    y = 1'b0;
    case (op)
      OP_AND:  y = &vec;
      OP_OR:   y = |vec;
      OP_NAND: y = ~&vec;
      OP_NOR:  y = ~|vec;
      OP_XOR:  y = ^vec;
      OP_XNOR: y = ~^vec;
      OP_BUF:  y = vec[0];
      OP_NOT:  y = ~vec[0];
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_truth_table_engine.sv
// Sweeps every input vector through nin_gate, streams each result and
// assembles the full truth table.
module gate_truth_table_engine
  import gate_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  gate_truth_table_engine_if.slave  bus
);

  localparam int TT_W = 2 ** N_IN;

  if (N_IN < N_IN_MIN || N_IN > N_IN_MAX) begin : g_bad_n_in
    $error("gate_truth_table_engine: N_IN out of range");
  end

  state_e          state_q, state_d;
  logic [N_IN-1:0] idx_q;
  op_e             op_q;
  logic [TT_W-1:0] tt_q;
  logic            bit_q;
  logic            vld_q;
  logic            y;
  logic            last;

  assign last = (idx_q == {N_IN{1'b1}});

  nin_gate #(.N_IN(N_IN)) u_gate (
    .vec (idx_q),
    .op  (op_q),
    .y   (y)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: single pass over all vectors, one drain cycle, one done cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_RUN;
      ST_RUN:   if (last)      state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath: latch op on accept, then record one result per RUN cycle.
  // idx saturates at the last vector so vec_out holds it after the sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= OP_AND;
      idx_q <= '0;
      tt_q  <= '0;
      bit_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= (state_q == ST_RUN);
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            op_q  <= bus.op;
            idx_q <= '0;
            tt_q  <= '0;
          end
        end
        ST_RUN: begin
          bit_q       <= y;
          tt_q[idx_q] <= y;
          if (!last) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.vec_out   = idx_q;
  assign bus.bit_out   = bit_q;
  assign bus.bit_valid = vld_q;
  assign bus.tt        = tt_q;

endmodule

// File: tb/tb_gate_truth_table_engine.sv
// Bench for gate_truth_table_engine: four instances (N_IN = 1, 2, 3, 6),
// table-driven sweeps with a scoreboard on the bit stream, plus reset corner cases.
module tb_gate_truth_table_engine;
  import gate_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gate_truth_table_engine_if #(.N_IN(1)) i1 ();
  gate_truth_table_engine_if #(.N_IN(2)) i2 ();
  gate_truth_table_engine_if #(.N_IN(3)) i3 ();
  gate_truth_table_engine_if #(.N_IN(6)) i6 ();

  gate_truth_table_engine #(.N_IN(1)) u1 (.clk(clk), .rst(rst), .bus(i1.slave));
  gate_truth_table_engine #(.N_IN(2)) u2 (.clk(clk), .rst(rst), .bus(i2.slave));
  gate_truth_table_engine #(.N_IN(3)) u3 (.clk(clk), .rst(rst), .bus(i3.slave));
  gate_truth_table_engine #(.N_IN(6)) u6 (.clk(clk), .rst(rst), .bus(i6.slave));

  int nsel [4] = '{1, 2, 3, 6};

  logic [63:0] tt_w   [4];
  logic [5:0]  vec_w  [4];
  logic        busy_w [4];
  logic        done_w [4];
  logic        bo_w   [4];
  logic        bv_w   [4];

  assign tt_w[0] = 64'(i1.tt);  assign vec_w[0] = 6'(i1.vec_out);
  assign tt_w[1] = 64'(i2.tt);  assign vec_w[1] = 6'(i2.vec_out);
  assign tt_w[2] = 64'(i3.tt);  assign vec_w[2] = 6'(i3.vec_out);
  assign tt_w[3] = 64'(i6.tt);  assign vec_w[3] = 6'(i6.vec_out);
  assign busy_w[0] = i1.busy; assign done_w[0] = i1.done; assign bo_w[0] = i1.bit_out; assign bv_w[0] = i1.bit_valid;
  assign busy_w[1] = i2.busy; assign done_w[1] = i2.done; assign bo_w[1] = i2.bit_out; assign bv_w[1] = i2.bit_valid;
  assign busy_w[2] = i3.busy; assign done_w[2] = i3.done; assign bo_w[2] = i3.bit_out; assign bv_w[2] = i3.bit_valid;
  assign busy_w[3] = i6.busy; assign done_w[3] = i6.done; assign bo_w[3] = i6.bit_out; assign bv_w[3] = i6.bit_valid;

  int   errs   = 0;
  int   checks = 0;
  logic exp_q [$];

  typedef struct {
    int          sel;
    int          op;
    logic [63:0] tt;
    bit          tog;
    bit          poke;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference gate: counts ones over the n inputs rather than reducing.
  function automatic logic model(input int n, input int o, input int v);
    int ones = 0;
    for (int i = 0; i < n; i++) ones += (v >> i) & 1;
    case (o)
      0: return logic'(ones == n);
      1: return logic'(ones != 0);
      2: return logic'(ones != n);
      3: return logic'(ones == 0);
      4: return logic'(ones % 2);
      5: return logic'((ones % 2) == 0);
      6: return logic'(v & 1);
      default: return logic'((v & 1) == 0);
    endcase
  endfunction

  task automatic set_in(input int sel, input logic s, input int o);
    case (sel)
      0: begin i1.start = s; i1.op = op_e'(o[2:0]); end
      1: begin i2.start = s; i2.op = op_e'(o[2:0]); end
      2: begin i3.start = s; i3.op = op_e'(o[2:0]); end
      default: begin i6.start = s; i6.op = op_e'(o[2:0]); end
    endcase
  endtask

  // Called at a negedge with the engine idle; returns at a negedge, idle again.
  task automatic run(input int sel, input int o, input logic [63:0] exp_tt,
                     input bit tog, input bit poke);
    int n = nsel[sel];
    int w = 1 << n;
    int c = 0;
    int nvalid = 0;
    bit busy_bad = 0;
    bit seen_done = 0;
    set_in(sel, 1'b1, o);
    @(posedge clk);
    #1 set_in(sel, 1'b0, o);
    for (int v = 0; v < w; v++) exp_q.push_back(model(n, o, v));
    while (!seen_done && c <= w + 4) begin
      @(negedge clk);
      if (c == 0) chk("vec_at_start", 64'(vec_w[sel]), 64'd0);
      if (tog && c == 1) set_in(sel, 1'b0, o ^ 5);
      if (poke && c == 2) set_in(sel, 1'b1, o);
      if (poke && c == 3) set_in(sel, 1'b0, o);
      if (bv_w[sel]) begin
        nvalid++;
        if (exp_q.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
        else chk("bit_out", 64'(bo_w[sel]), 64'(exp_q.pop_front()));
      end
      if (c <= w && !busy_w[sel]) busy_bad = 1;
      if (done_w[sel]) begin
        seen_done = 1;
        chk("done_latency", 64'(c), 64'(w + 1));
        chk("tt", tt_w[sel], exp_tt);
        chk("vec_hold", 64'(vec_w[sel]), 64'(w - 1));
        chk("busy_at_done", 64'(busy_w[sel]), 64'd0);
      end
      c++;
    end
    if (!seen_done) chk("done_seen", 64'd0, 64'd1);
    chk("valid_cycles", 64'(nvalid), 64'(w));
    chk("busy_window", 64'(busy_bad), 64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clk);
    chk("idle_after", 64'(busy_w[sel] | done_w[sel]), 64'd0);
    chk("tt_hold", tt_w[sel], exp_tt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit any_busy;
    for (int s = 0; s < 4; s++) set_in(s, 1'b0, 0);

    tbl[0]  = '{1, 3, 64'h1,  0, 0};
    tbl[1]  = '{1, 2, 64'h7,  0, 1};
    tbl[2]  = '{1, 0, 64'h8,  0, 0};
    tbl[3]  = '{2, 4, 64'h96, 0, 1};
    tbl[4]  = '{2, 5, 64'h69, 0, 0};
    tbl[5]  = '{2, 0, 64'h80, 0, 0};
    tbl[6]  = '{2, 1, 64'hFE, 0, 0};
    tbl[7]  = '{2, 6, 64'hAA, 1, 0};
    tbl[8]  = '{2, 7, 64'h55, 1, 0};
    tbl[9]  = '{0, 3, 64'h1,  0, 0};
    tbl[10] = '{0, 0, 64'h2,  0, 0};
    tbl[11] = '{3, 0, 64'h8000_0000_0000_0000, 0, 0};

    // Reset state of every instance.
    #12;
    for (int s = 0; s < 4; s++) begin
      chk("rst_tt", tt_w[s], 64'd0);
      chk("rst_outs", {58'd0, vec_w[s]} | 64'({busy_w[s], done_w[s], bo_w[s], bv_w[s]}), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) run(tbl[i].sel, tbl[i].op, tbl[i].tt, tbl[i].tog, tbl[i].poke);

    // Asynchronous reset at idx=2 of an N_IN=3 XOR sweep.
    set_in(2, 1'b1, 4);
    @(posedge clk);
    #1 set_in(2, 1'b0, 4);
    repeat (3) @(negedge clk);
    chk("pre_rst_vec", 64'(vec_w[2]), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_busy",  64'(busy_w[2]), 64'd0);
    chk("rst_mid_valid", 64'(bv_w[2]),   64'd0);
    chk("rst_mid_tt",    tt_w[2],        64'd0);
    chk("rst_mid_vec",   64'(vec_w[2]),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    any_busy = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy_w[2] || done_w[2]) any_busy = 1;
    end
    chk("no_done_after_rst", 64'(any_busy), 64'd0);
    run(2, 4, 64'h96, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/gate_truth_table_engine.md
Name: gate_truth_table_engine

Overview:
- Parametrised successor to the team's fixed 2-input gate cells: one N-input logic gate with a run-time selectable function.
- Wrapped in a sequencer that sweeps every input combination, streams each result, and assembles the full truth table in a register.
- Used as an on-chip self-test and characterisation block for the logic-gate library, replacing hand-written stimulus sequences.

Parameters:
- N_IN, 2, number of gate inputs; legal range 1..6.
- TT_W, 2**N_IN, truth-table width; derived, not overridable.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request a sweep; sampled only in IDLE.
- op  in  3  gate function, latched at start acceptance.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when the truth table is complete.
- vec_out  out  N_IN  input vector currently applied to the gate.
- bit_out  out  1  registered gate result for the previous vector.
- bit_valid  out  1  bit_out is valid this cycle.
- tt  out  TT_W  assembled truth table; bit k is the result for input vector k.

Behaviour:
- Reset:
  - Asynchronous active-high reset on rst; clk is the only clock.
  - On assertion: state=IDLE; busy, done, bit_valid, bit_out=0; vec_out=0; tt=0; latched op=0.
- op encoding, applied to input vector v, with v[0] as input 0:
  - 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR (odd parity), 5 XNOR.
  - 6 BUF (v[0]), 7 NOT (~v[0]).
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On the rising edge E0 with start=1: latch op, clear tt to 0, set idx=0, busy=1, go to RUN.
- RUN:
  - vec_out=idx; gate evaluates combinationally on idx.
  - At each edge: bit_out<=result, bit_valid<=1, tt[idx]<=result, idx<=idx+1.
  - At the edge with idx=TT_W-1, go to DRAIN. The counter does not wrap into a second pass.
- DRAIN:
  - One cycle; bit_valid<=0 at its closing edge.
  - At that edge done<=1, busy<=0, go to DONE.
- DONE:
  - One cycle; done<=0 at its closing edge; return to IDLE.
  - start in this cycle is ignored.
- Latency, start accepted at edge E0:
  - Result for vector k is on bit_out and in tt[k] after edge E0+k+1, with bit_valid high.
  - done is high for the cycle following edge E0+TT_W+1.
  - busy is high from E0 until that same edge.
- tt is stable and holds its value from done until the next accepted start.
- start while busy or in DONE: ignored, no queuing.
- op changes mid-sweep: no effect, because the latched op is used.
- rst mid-sweep: immediate abort, all outputs to reset values, partial tt discarded.
- vec_out holds its last value (TT_W-1) after the sweep until the next start or reset.
- N_IN=1: TT_W=2; AND, OR and XOR degenerate to BUF, while NAND, NOR and XNOR degenerate to NOT.

Decomposition:
- Shared package gate_pkg holds:
  - the op enum (OP_AND..OP_NOT), 3 bits;
  - the state enum;
  - constants N_IN_MIN=1 and N_IN_MAX=6.
- One natural sub-module, nin_gate: purely combinational, parameter N_IN, inputs vec and op, output y.
- Top level holds the FSM, index counter and truth-table register.

Test Plan:
- N_IN=2, op=3 (NOR), start pulse -> bit_out stream 1,0,0,0 with bit_valid for 4 cycles; tt=4'b0001; done exactly 5 cycles after the start edge.
- N_IN=2, op=2 (NAND) then op=0 (AND) back-to-back, second start issued the cycle after done returns to IDLE -> tt=4'b0111, then tt=4'b1000; start raised during busy is ignored.
- N_IN=3, op=4 (XOR) -> tt=8'h96; op=5 (XNOR) -> tt=8'h69; op=0 (AND) -> tt=8'h80; op=1 (OR) -> tt=8'hFE.
- N_IN=3, op=6 (BUF) -> tt=8'hAA; op=7 (NOT) -> tt=8'h55; toggling op mid-sweep does not alter the result.
- rst asserted asynchronously mid-sweep at idx=2 -> busy, bit_valid, tt and vec_out go to 0 immediately; no done pulse; a new start afterwards yields a correct full table.
- N_IN=1, op=3 -> tt=2'b01, done 3 cycles after start; N_IN=6, op=0 -> tt has only bit 63 set, done 65 cycles after start.
